// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and the stall/flush controller.
// The datapath drives the master side and the controller drives the slave side.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_dreq;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             branch_taken;
    logic             halt_mem;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             memwb_flush;
    logic             dreq_mask;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ihit, dhit, mem_dreq, idex_memread, idex_rd, ifid_rs, ifid_rt,
               branch_taken, halt_mem,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, memwb_flush, dreq_mask, halt_out, stall_cnt
    );

    modport slave (
        input  ihit, dhit, mem_dreq, idex_memread, idex_rd, ifid_rs, ifid_rt,
               branch_taken, halt_mem,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, memwb_flush, dreq_mask, halt_out, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: reconciles split memory
// hits with sticky latches and decodes per-register enable/flush pairs.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic            CLK,
    input logic            nRST,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t           state, next_state;
    logic             ihit_q, dhit_q;
    logic             fe_ready, be_ready, step, lu;
    logic [CNT_W-1:0] cnt;

    assign fe_ready = bus.ihit | ihit_q;
    assign be_ready = ~bus.mem_dreq | bus.dhit | dhit_q;
    assign step     = (state == RUN) & fe_ready & be_ready;
    assign lu       = bus.idex_memread & (bus.idex_rd != 5'd0) &
                      ((bus.idex_rd == bus.ifid_rs) | (bus.idex_rd == bus.ifid_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == RUN && step && bus.halt_mem) next_state = HALT;
    end

    // Flags remember a hit from one port while the other port is still outstanding.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
        end else if (state == RUN) begin
            if (step) begin
                ihit_q <= 1'b0;
                dhit_q <= 1'b0;
            end else begin
                ihit_q <= ihit_q | bus.ihit;
                dhit_q <= dhit_q | (bus.dhit & bus.mem_dreq);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                                  cnt <= '0;
        else if (state == RUN && !step && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign bus.stall_cnt = cnt;
    assign bus.dreq_mask = dhit_q;

    always_comb begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_en     = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_en    = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.memwb_en    = 1'b0;
        bus.memwb_flush = 1'b0;
        bus.halt_out    = (state == HALT);
        if (state == RUN) begin
            if (!step) begin
                // Bubble into WB so a stalled instruction never writes twice.
                bus.memwb_en    = 1'b1;
                bus.memwb_flush = 1'b1;
            end else if (bus.halt_mem || bus.branch_taken) begin
                bus.pc_en       = bus.branch_taken & ~bus.halt_mem;
                bus.ifid_en     = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_en     = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_en    = 1'b1;
                bus.exmem_flush = 1'b1;
                bus.memwb_en    = 1'b1;
            end else if (lu) begin
                bus.idex_en     = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_en    = 1'b1;
                bus.memwb_en    = 1'b1;
            end else begin
                bus.pc_en       = 1'b1;
                bus.ifid_en     = 1'b1;
                bus.idex_en     = 1'b1;
                bus.exmem_en    = 1'b1;
                bus.memwb_en    = 1'b1;
            end
        end
    end
endmodule
